busca_instrucao: RTL

BUSCA_INSTRUCAO -- requirements
Module: busca_instrucao

---
 rtl/busca_instrucao.sv | 126 ++++++++++++
 1 files changed

// File: rtl/busca_instrucao.sv
// Instruction fetch stage: program counter, memory read handshake with timeout,
// and instruction register with combinational field decode.
module busca_instrucao #(
  parameter int LARG_CP       = 8,
  parameter int LARG_INSTR    = 16,
  parameter int LIMITE_ESPERA = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  EscCP,
  input  logic                  EscCondCP,
  input  logic                  zero,
  input  logic [1:0]            FonteCP,
  input  logic [LARG_INSTR-1:0] ula_saida,
  input  logic                  EscIR,
  output logic                  mem_req,
  output logic [LARG_CP-1:0]    mem_addr,
  input  logic                  mem_ack,
  input  logic [LARG_INSTR-1:0] mem_dado,
  output logic [3:0]            opcode,
  output logic [3:0]            rd,
  output logic [3:0]            rs,
  output logic [3:0]            rt,
  output logic [7:0]            imediato,
  output logic [LARG_CP-1:0]    cp,
  output logic                  ir_valido,
  output logic                  ocupado,
  output logic                  erro_busca
);

  // state  | meaning
  // OCIOSO | no fetch in flight; IR invalid (after reset or timeout)
  // BUSCA  | read request outstanding, waiting for mem_ack
  // PRONTO | IR holds a completed fetch
  typedef enum logic [1:0] {OCIOSO, BUSCA, PRONTO} estado_t;

  localparam int LARG_CNT = $clog2(LIMITE_ESPERA + 1);

  estado_t               estado_q, estado_d;
  logic [LARG_CP-1:0]    cp_q, cp_d;
  logic [LARG_CP-1:0]    mem_addr_q, mem_addr_d;
  logic [LARG_INSTR-1:0] ir_q, ir_d;
  logic [LARG_CNT-1:0]   cnt_q, cnt_d;
  logic                  erro_q, erro_d;
  logic                  esc_cp;
  logic                  unused_ula;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q   <= OCIOSO;
      cp_q       <= '0;
      mem_addr_q <= '0;
      ir_q       <= '0;
      cnt_q      <= '0;
      erro_q     <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      cp_q       <= cp_d;
      mem_addr_q <= mem_addr_d;
      ir_q       <= ir_d;
      cnt_q      <= cnt_d;
      erro_q     <= erro_d;
    end
  end

  always_comb begin
    estado_d   = estado_q;
    mem_addr_d = mem_addr_q;
    ir_d       = ir_q;
    cnt_d      = cnt_q;
    erro_d     = erro_q;
    case (estado_q)
      OCIOSO, PRONTO: begin
        // the address is the pre-edge cp, so a same-edge PC write hits the next fetch
        if (EscIR) begin
          estado_d   = BUSCA;
          mem_addr_d = cp_q;
          erro_d     = 1'b0;
          cnt_d      = '0;
        end
      end
      BUSCA: begin
        if (mem_ack) begin
          ir_d     = mem_dado;
          estado_d = PRONTO;
        end else begin
          cnt_d = cnt_q + LARG_CNT'(1);
          if (cnt_d == LARG_CNT'(LIMITE_ESPERA)) begin
            erro_d   = 1'b1;
            estado_d = OCIOSO;
          end
        end
      end
      default: estado_d = OCIOSO;
    endcase
  end

  assign esc_cp = EscCP | (EscCondCP & zero);

  always_comb begin
    cp_d = cp_q;
    if (esc_cp) begin
      case (FonteCP)
        2'b00:   cp_d = cp_q + LARG_CP'(1);
        2'b01:   cp_d = ula_saida[LARG_CP-1:0];
        2'b10:   cp_d = LARG_CP'(ir_q[7:0]);
        default: cp_d = cp_q;
      endcase
    end
  end

  assign unused_ula = ^ula_saida[LARG_INSTR-1:LARG_CP];

  assign mem_req    = (estado_q == BUSCA);
  assign ocupado    = (estado_q == BUSCA);
  assign ir_valido  = (estado_q == PRONTO);
  assign erro_busca = erro_q;
  assign mem_addr   = mem_addr_q;
  assign cp         = cp_q;
  assign opcode     = ir_q[15:12];
  assign rd         = ir_q[11:8];
  assign rs         = ir_q[7:4];
  assign rt         = ir_q[3:0];
  assign imediato   = ir_q[7:0];

endmodule
